// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice of the 16-bit core.
package fetch_pkg;

  typedef enum logic [2:0] {
    NE     = 3'd0,
    EQ     = 3'd1,
    GT     = 3'd2,
    LT     = 3'd3,
    GE     = 3'd4,
    LE     = 3'd5,
    OV     = 3'd6,
    UNCOND = 3'd7
  } cond_t;

  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fstate_t;

endpackage

// File: rtl/fetch_sequencer_branch_eval.sv
// Branch resolution: condition test against {V,N,Z} and next-PC target selection.
module branch_eval
  import fetch_pkg::*;
(
  input  logic [2:0]  cond,
  input  logic [2:0]  flags,
  input  logic        br_reg,
  input  logic [15:0] pc_plus2,
  input  logic [8:0]  imm,
  input  logic [15:0] rs_val,
  output logic        taken,
  output logic [15:0] target
);

  logic        flag_v;
  logic        flag_n;
  logic        flag_z;
  logic [15:0] offset;

  always_comb begin
    flag_v = flags[FLAG_V];
    flag_n = flags[FLAG_N];
    flag_z = flags[FLAG_Z];
  end

  always_comb begin
    taken = 1'b0;
    unique case (cond_t'(cond))
      NE:      taken = ~flag_z;
      EQ:      taken = flag_z;
      GT:      taken = ~flag_z & ~flag_n;
      LT:      taken = flag_n;
      GE:      taken = flag_z | ~flag_n;
      LE:      taken = flag_z | flag_n;
      OV:      taken = flag_v;
      UNCOND:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^16.
  always_comb begin
    offset = {{6{imm[8]}}, imm, 1'b0};
    target = br_reg ? rs_val : (pc_plus2 + offset);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the imem hold-until-valid
// handshake, applies taken-branch redirects and buffers one word across stalls.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [2:0]  br_flags,
  input  logic        br_reg,
  input  logic [15:0] br_pc_plus2,
  input  logic [8:0]  br_imm,
  input  logic [15:0] br_rs_val,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_plus2,
  output logic        flush,
  output logic        halted,
  output logic [15:0] pc
);

  fstate_t     state;
  logic [15:0] req_addr;
  logic        hold_valid;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc2;

  logic        taken;
  logic [15:0] target;
  logic        redirect;
  logic        fetch_done;
  logic        fetch_hlt;
  logic [15:0] pc_next;

  branch_eval u_branch_eval (
    .cond     (br_cond),
    .flags    (br_flags),
    .br_reg   (br_reg),
    .pc_plus2 (br_pc_plus2),
    .imm      (br_imm),
    .rs_val   (br_rs_val),
    .taken    (taken),
    .target   (target)
  );

  // pc only moves on completion, so in RUN it doubles as the stable request
  // address; DRAIN must keep presenting the pre-redirect address instead.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    unique case (state)
      RUN:     imem_req = ~hold_valid;
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
      end
      default: imem_req = 1'b0;
    endcase
    if (!rst_n) imem_req = 1'b0;
  end

  always_comb begin
    redirect   = br_valid & taken;
    flush      = redirect;
    fetch_done = (state == RUN) & imem_req & imem_valid;
    fetch_hlt  = (imem_data[15:12] == OPC_HLT);
    pc_next    = pc + 16'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= '0;
      req_addr    <= '0;
      hold_valid  <= 1'b0;
      hold_instr  <= '0;
      hold_pc2    <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc_plus2 <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc         <= target;
      hold_valid <= 1'b0;
      if_valid   <= 1'b0;
      halted     <= 1'b0;
      unique case (state)
        RUN: begin
          if (imem_req && !imem_valid) begin
            state    <= DRAIN;
            req_addr <= pc;
          end
        end
        DRAIN:   if (imem_valid) state <= RUN;
        default: state <= RUN;
      endcase
    end else begin
      if (!stall) begin
        if (hold_valid) begin
          if_valid    <= 1'b1;
          if_instr    <= hold_instr;
          if_pc_plus2 <= hold_pc2;
          hold_valid  <= 1'b0;
          if (hold_instr[15:12] == OPC_HLT) halted <= 1'b1;
        end else if (fetch_done) begin
          if_valid    <= 1'b1;
          if_instr    <= imem_data;
          if_pc_plus2 <= pc_next;
          if (fetch_hlt) halted <= 1'b1;
        end else begin
          if_valid <= 1'b0;
        end
      end else if (fetch_done) begin
        hold_valid <= 1'b1;
        hold_instr <= imem_data;
        hold_pc2   <= pc_next;
      end

      unique case (state)
        RUN: begin
          if (fetch_done) begin
            if (fetch_hlt) state <= HALT;
            else           pc    <= pc_next;
          end
        end
        DRAIN:   if (imem_valid) state <= RUN;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences the next-PC datapath. It issues requests to instruction memory under a hold-until-valid handshake and evaluates branch conditions against the flag register. It applies taken-branch redirects with squash of in-flight fetches, buffers one fetched word across IF/ID stalls, and halts on HLT. It sits between instruction memory and the IF/ID pipeline register.

## Interface
- No parameters; all widths fixed (16-bit ISA).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  IF/ID hold request from hazard unit
- br_valid  in  1  branch resolving in ID this cycle
- br_cond  in  3  condition code
- br_flags  in  3  {V,N,Z} = bits [2],[1],[0]
- br_reg  in  1  1 = register-target branch (BR), 0 = PC-relative (B)
- br_pc_plus2  in  16  PC+2 of the branch instruction
- br_imm  in  9  signed word offset
- br_rs_val  in  16  register target for BR
- imem_req  out  1  fetch request
- imem_addr  out  16  fetch address, stable while imem_req high
- imem_valid  in  1  fetch data valid (same or any later cycle)
- imem_data  in  16  fetched instruction
- if_valid  out  1  IF/ID contents valid
- if_instr  out  16  fetched instruction
- if_pc_plus2  out  16  fetch address + 2
- flush  out  1  combinational; br_valid & taken, kills the younger IF/ID instruction
- halted  out  1  HLT fetched and committed to IF/ID
- pc  out  16  current next-fetch PC

## Operation
- Taken conditions:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z&~N
  - 011 LT: N
  - 100 GE: Z|~N
  - 101 LE: Z|N
  - 110 OV: V
  - 111: always
- Target: br_reg ? br_rs_val : br_pc_plus2 + (sext(br_imm)<<1), modulo 2^16 (wrap, no error).
- States:
  - RUN: normal fetch.
  - DRAIN: discarding a squashed fetch.
  - HALT: fetch stopped after HLT.
- Registers: req_addr (address of outstanding request), one-entry hold buffer (hold_valid, hold_instr, hold_pc2).
- Handshake: once imem_req rises it stays high with req_addr unchanged until imem_valid. Completion = imem_req & imem_valid.
- RUN:
  - imem_req = ~hold_valid; imem_addr = pc at launch.
  - On completion, pc <= pc+2.
  - Completed data goes to the IF/ID output if stall=0, else to the hold buffer.
- stall=0 with hold_valid: output loads from hold, hold clears. imem_req is 0 that cycle.
- stall=1: if_* hold their values.
- Taken redirect has priority over everything:
  - pc <= target, hold cleared, if_valid <= 0 regardless of stall.
  - If the request is outstanding without imem_valid: go to DRAIN.
  - If imem_valid arrives in the redirect cycle: data is dropped, stay in RUN.
- DRAIN:
  - imem_req held at old req_addr until imem_valid; data discarded; then RUN at pc.
  - A further redirect in DRAIN updates pc and stays in DRAIN.
- HLT (imem_data[15:12]==4'hF), non-squashed completion:
  - Word delivered normally (direct or via hold); state goes to HALT; pc not advanced.
  - halted asserts when the HLT word is in if_instr.
- HALT:
  - imem_req=0.
  - A taken redirect clears halted, loads pc, returns to RUN (HLT was wrong-path).
- Not-taken br_valid: no effect.

## Timing
- Reset values: pc=0x0000, state RUN, imem_req=0 during reset, if_valid=0, if_instr=0, if_pc_plus2=0, hold_valid=0, halted=0.
- First request (addr 0x0000) asserted in the first cycle after rst_n deasserts.
- With zero-wait memory and no stall: one instruction per cycle. Data completing at edge N is visible on if_* after edge N.
- Redirect at edge N with no outstanding request: target request issued in cycle N+1.
- Redirect at edge N with an outstanding request: DRAIN for k cycles, then the target request is issued the cycle after the drained completion.
- flush has zero latency, asserted in the br_valid cycle.
- Reset mid-fetch: all state cleared immediately. The memory sees imem_req drop; this is allowed only under reset.

## Structure
- Shared package fetch_pkg:
  - cond_t enum (NE..UNCOND).
  - Flag bit indices FLAG_V=2, FLAG_N=1, FLAG_Z=0.
  - OPC_HLT=4'hF.
  - fstate_t {RUN, DRAIN, HALT}.
- Sub-module branch_eval (combinational): cond, flags, reg/imm inputs -> taken, target.

## Test plan
- Reset release, imem_valid tied 1, data 0x1000.. -> requests 0x0000, 0x0002, 0x0004 on consecutive cycles; if_pc_plus2 = 0x0002, 0x0004.
- br_valid, cond=001, Z=1, br_pc_plus2=0x0010, imm=-3 -> flush=1 that cycle, if_valid=0 next, next imem_addr=0x000A. Same with Z=0 -> no flush, sequence unchanged.
- 3-cycle memory latency, redirect to 0x0040 in cycle 1 of the wait -> req held at old addr until valid, data never reaches if_instr, then request 0x0040.
- stall=1 during completion of 0x0006 -> if_* unchanged, no new request. Release stall -> if_instr = word@0x0006, request 0x0008 the following cycle.
- Fetch 0xF000 at 0x0020 -> halted=1, imem_req=0, pc=0x0020. Then BR cond=111, rs=0x0100 -> halted=0, request 0x0100.
- imm=+255 with br_pc_plus2=0xFF00 -> target 0x00FE (wrap).
